// File: rtl/wishbone_master_pkg.sv
// Shared types and bus widths for the Wishbone master.
package wishbone_master_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  // Bus access state machine encodings
  typedef enum logic [1:0] {
    StIdle         = 2'd0,
    StBusy         = 2'd1,
    StWaitForStall = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone classic master bridging a CPU pipeline port to the bus.
// One access at a time; a timeout aborts accesses the slave never acknowledges.
module wishbone_master
  import wishbone_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU side
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [WB_ADDR_W-1:0] cpu_addr_i,
  input  logic [WB_DATA_W-1:0] cpu_data_i,
  input  logic [WB_SEL_W-1:0]  cpu_sel_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic [WB_DATA_W-1:0] cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 cpu_err_o,
  // Wishbone side
  output logic [WB_ADDR_W-1:0] wishbone_addr_o,
  output logic [WB_DATA_W-1:0] wishbone_data_o,
  output logic                 wishbone_we_o,
  output logic [WB_SEL_W-1:0]  wishbone_select_o,
  output logic                 wishbone_stb_o,
  output logic                 wishbone_cyc_o,
  input  logic [WB_DATA_W-1:0] wishbone_data_i,
  input  logic                 wishbone_ack_i
);

  // Last counter value of a BUSY phase; an unacked access aborts on it.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  wb_state_e            state_q, state_d;
  logic [WB_ADDR_W-1:0] addr_q, addr_d;
  logic [WB_DATA_W-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic                 stb_q, stb_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [WB_DATA_W-1:0] rbuf_q, rbuf_d;
  logic                 err_q, err_d;

  logic busy;
  logic ack_taken;

  assign busy = (state_q == StBusy);
  // An ack only counts when neither reset nor flush cancels it in the same cycle.
  assign ack_taken = busy && wishbone_ack_i && !flush_i && !rst;

  // Next-state and registered-output logic of the access FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    sel_d   = sel_q;
    stb_d   = stb_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (cpu_req_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        if (flush_i) begin
          // Flush wins over ack and timeout: drop the access and its result.
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          rbuf_d  = '0;
          state_d = StIdle;
        end else if (wishbone_ack_i) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          rbuf_d  = we_q ? '0 : wishbone_data_i;
          state_d = stall_i ? StWaitForStall : StIdle;
        end else if (cnt_q == TimeoutLast) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          rbuf_d  = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StWaitForStall: begin
        // Result is held in rbuf_q until the pipeline can take it.
        if (!stall_i || flush_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  // CPU-facing combinational outputs: stall handshake and read-data bypass
  always_comb begin
    cpu_stall_o = 1'b0;
    unique case (state_q)
      StIdle:  cpu_stall_o = cpu_req_i && !flush_i;
      StBusy:  cpu_stall_o = !wishbone_ack_i;
      default: cpu_stall_o = 1'b0;
    endcase
    cpu_data_o = ack_taken ? wishbone_data_i : rbuf_q;
  end

  assign cpu_err_o         = err_q;
  assign wishbone_addr_o   = addr_q;
  assign wishbone_data_o   = wdata_q;
  assign wishbone_we_o     = we_q;
  assign wishbone_select_o = sel_q;
  // stb and cyc come from one register so they can never disagree.
  assign wishbone_stb_o    = stb_q;
  assign wishbone_cyc_o    = stb_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Self-checking bench for wishbone_master: vector table plus multi-cycle corner sequences.
module tb_wishbone_master;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] cpu_data_o;
  logic        cpu_stall_o;
  logic        cpu_err_o;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_select_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
  logic [31:0] wishbone_data_i = '0;
  logic        wishbone_ack_i = 1'b0;

  always #5 clk = ~clk;

  wishbone_master #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_req_i         (cpu_req_i),
    .cpu_we_i          (cpu_we_i),
    .cpu_addr_i        (cpu_addr_i),
    .cpu_data_i        (cpu_data_i),
    .cpu_sel_i         (cpu_sel_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .cpu_data_o        (cpu_data_o),
    .cpu_stall_o       (cpu_stall_o),
    .cpu_err_o         (cpu_err_o),
    .wishbone_addr_o   (wishbone_addr_o),
    .wishbone_data_o   (wishbone_data_o),
    .wishbone_we_o     (wishbone_we_o),
    .wishbone_select_o (wishbone_select_o),
    .wishbone_stb_o    (wishbone_stb_o),
    .wishbone_cyc_o    (wishbone_cyc_o),
    .wishbone_data_i   (wishbone_data_i),
    .wishbone_ack_i    (wishbone_ack_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          busy;   // cycles with stb high, ack in the last one
    logic [31:0] rdata;  // slave data driven in the ack cycle
    int          stall;  // extra WAIT_FOR_STALL cycles with stall_i held
    logic        flush;  // flush coincides with ack
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted ack must show the slave data on cpu_data_o with stall released.
  always @(negedge clk) begin : sb_mon
    logic [31:0] e;
    if (!rst && !flush_i && wishbone_ack_i && wishbone_cyc_o) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: ack seen with data 0x%08h, expected no ack", cpu_data_o);
      end else begin
        e = sb_q.pop_front();
        check("sb_ack_data", cpu_data_o, e);
        check("sb_ack_stall", {31'd0, cpu_stall_o}, 32'd0);
      end
    end
  end

  task automatic check_idle_bus(input string tag);
    check({tag, "_cyc"}, {31'd0, wishbone_cyc_o}, 32'd0);
    check({tag, "_stb"}, {31'd0, wishbone_stb_o}, 32'd0);
    check({tag, "_we"}, {31'd0, wishbone_we_o}, 32'd0);
    check({tag, "_sel"}, {28'd0, wishbone_select_o}, 32'd0);
  endtask

  // Drives one access from IDLE to completion; returns at posedge+1 with the DUT in IDLE.
  task automatic run_txn(input vec_t v);
    logic [31:0] exp_buf;
    cpu_req_i  = 1'b1;
    cpu_we_i   = v.we;
    cpu_addr_i = v.addr;
    cpu_data_i = v.wdata;
    cpu_sel_i  = v.sel;
    @(negedge clk);
    check("idle_req_stall", {31'd0, cpu_stall_o}, 32'd1);
    check("idle_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    for (int i = 1; i <= v.busy; i++) begin
      tick();
      if (i == v.busy) begin
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = v.rdata;
        stall_i         = (v.stall > 0);
        flush_i         = v.flush;
        if (!v.flush) sb_q.push_back(v.rdata);
      end
      @(negedge clk);
      check("busy_cyc", {31'd0, wishbone_cyc_o}, 32'd1);
      check("busy_stb", {31'd0, wishbone_stb_o}, 32'd1);
      check("busy_addr", wishbone_addr_o, v.addr);
      check("busy_wdata", wishbone_data_o, v.wdata);
      check("busy_we", {31'd0, wishbone_we_o}, {31'd0, v.we});
      check("busy_sel", {28'd0, wishbone_select_o}, {28'd0, v.sel});
      if (i < v.busy) check("busy_stall", {31'd0, cpu_stall_o}, 32'd1);
    end
    tick();
    wishbone_ack_i  = 1'b0;
    wishbone_data_i = 32'h5A5A_0000;
    flush_i         = 1'b0;
    cpu_req_i       = 1'b0;
    exp_buf = (v.flush || v.we) ? 32'd0 : v.rdata;
    if (v.stall > 0) begin
      // Requests during WAIT_FOR_STALL must be ignored.
      cpu_req_i = 1'b1;
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        check("wait_data", cpu_data_o, exp_buf);
        check("wait_stall", {31'd0, cpu_stall_o}, 32'd0);
        check("wait_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
        tick();
      end
      cpu_req_i = 1'b0;
      stall_i   = 1'b0;
      @(negedge clk);
      check("wait_last_data", cpu_data_o, exp_buf);
      tick();
    end
    @(negedge clk);
    check_idle_bus("post");
    check("post_data", cpu_data_o, exp_buf);
    check("post_err", {31'd0, cpu_err_o}, 32'd0);
    check("post_stall", {31'd0, cpu_stall_o}, 32'd0);
    tick();
  endtask

  task automatic start_read(input logic [31:0] addr);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = addr;
    cpu_data_i = 32'h0;
    cpu_sel_i  = 4'hF;
  endtask

  initial begin
    int   busy_cnt;
    vec_t rd;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 2, 32'hFFFF_0000, 0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 32'hA5A5_A5A5, 4, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 32'h1111_2222, 0, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h0, 4'hC, 7, 32'h0BAD_F00D, 0, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0048, 32'h0, 4'hF, 8, 32'hCAFE_F00D, 0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0050, 32'h89AB_CDEF, 4'h1, 1, 32'h0000_0000, 0, 1'b0};
    rd      = '{1'b0, 32'h0000_0070, 32'h0, 4'hF, 1, 32'h1357_9BDF, 0, 1'b0};

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check_idle_bus("rst");
    check("rst_addr", wishbone_addr_o, 32'd0);
    check("rst_wdata", wishbone_data_o, 32'd0);
    check("rst_data", cpu_data_o, 32'd0);
    check("rst_err", {31'd0, cpu_err_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) run_txn(vecs[k]);

    // Back-to-back requests: one IDLE cycle must separate the two accesses
    start_read(32'h0000_0090);
    tick();
    wishbone_ack_i  = 1'b1;
    wishbone_data_i = 32'h2468_ACE0;
    sb_q.push_back(32'h2468_ACE0);
    @(negedge clk);
    tick();
    wishbone_ack_i = 1'b0;
    @(negedge clk);
    check("b2b_gap_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    check("b2b_gap_stall", {31'd0, cpu_stall_o}, 32'd1);
    check("b2b_gap_data", cpu_data_o, 32'h2468_ACE0);
    tick();
    cpu_req_i = 1'b0;
    @(negedge clk);
    check("b2b_second_cyc", {31'd0, wishbone_cyc_o}, 32'd1);
    tick();
    wishbone_ack_i  = 1'b1;
    wishbone_data_i = 32'h0000_0001;
    sb_q.push_back(32'h0000_0001);
    @(negedge clk);
    tick();
    wishbone_ack_i = 1'b0;
    @(negedge clk);
    check("b2b_end_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    check("b2b_end_data", cpu_data_o, 32'h0000_0001);
    tick();

    // Flush mid-BUSY without ack: buffer cleared, no error
    start_read(32'h0000_00A0);
    tick();
    cpu_req_i = 1'b0;
    @(negedge clk);
    check("fl_busy_cyc", {31'd0, wishbone_cyc_o}, 32'd1);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("fl_busy_stall", {31'd0, cpu_stall_o}, 32'd1);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check_idle_bus("fl");
    check("fl_data", cpu_data_o, 32'd0);
    check("fl_err", {31'd0, cpu_err_o}, 32'd0);
    tick();

    // Reset in BUSY cycle 2 with a simultaneous ack
    run_txn(rd);
    start_read(32'h0000_0080);
    tick();
    cpu_req_i = 1'b0;
    @(negedge clk);
    check("rb_c1_cyc", {31'd0, wishbone_cyc_o}, 32'd1);
    tick();
    rst             = 1'b1;
    wishbone_ack_i  = 1'b1;
    wishbone_data_i = 32'h7777_7777;
    @(negedge clk);
    tick();
    rst            = 1'b0;
    wishbone_ack_i = 1'b0;
    @(negedge clk);
    check_idle_bus("rb");
    check("rb_addr", wishbone_addr_o, 32'd0);
    check("rb_wdata", wishbone_data_o, 32'd0);
    check("rb_data", cpu_data_o, 32'd0);
    check("rb_err", {31'd0, cpu_err_o}, 32'd0);
    tick();
    @(negedge clk);
    check("rb_stay_idle", {31'd0, wishbone_cyc_o}, 32'd0);
    tick();

    // Timeout: no ack, cyc high for exactly TO cycles, then a one-cycle error
    run_txn(rd);
    start_read(32'h0000_0060);
    tick();
    cpu_req_i = 1'b0;
    busy_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!wishbone_cyc_o) break;
      busy_cnt++;
      tick();
    end
    check("to_busy_cycles", busy_cnt, TO);
    check("to_err_pulse", {31'd0, cpu_err_o}, 32'd1);
    check("to_data", cpu_data_o, 32'd0);
    check("to_stall", {31'd0, cpu_stall_o}, 32'd0);
    tick();
    @(negedge clk);
    check("to_err_clear", {31'd0, cpu_err_o}, 32'd0);
    check("to_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    tick();

    // Request together with flush in IDLE is not started
    cpu_req_i = 1'b1;
    flush_i   = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", {31'd0, cpu_stall_o}, 32'd0);
    tick();
    cpu_req_i = 1'b0;
    flush_i   = 1'b0;
    @(negedge clk);
    check("idle_flush_cyc", {31'd0, wishbone_cyc_o}, 32'd0);
    tick();

    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_master.md
WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 Parameter TIMEOUT, default 255; maximum BUSY cycles without ack before abort, 1..65535.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_req_i  in  1  CPU requests an access this cycle.
REQ-005 cpu_we_i  in  1  1 = write, 0 = read.
REQ-006 cpu_addr_i  in  32  byte address.
REQ-007 cpu_data_i  in  32  write data.
REQ-008 cpu_sel_i  in  4  byte lane enables.
REQ-009 stall_i  in  1  pipeline stalled; the CPU cannot yet consume the result.
REQ-010 flush_i  in  1  pipeline flush; cancel any access in flight.
REQ-011 cpu_data_o  out  32  read result.
REQ-012 cpu_stall_o  out  1  the CPU must hold its request.
REQ-013 cpu_err_o  out  1  one-cycle pulse on timeout abort.
REQ-014 wishbone_addr_o  out  32  Wishbone address.
REQ-015 wishbone_data_o  out  32  Wishbone write data.
REQ-016 wishbone_we_o  out  1  Wishbone write enable.
REQ-017 wishbone_select_o  out  4  Wishbone byte select.
REQ-018 wishbone_stb_o  out  1  Wishbone strobe.
REQ-019 wishbone_cyc_o  out  1  Wishbone cycle.
REQ-020 wishbone_data_i  in  32  read data from the slave (bus).
REQ-021 wishbone_ack_i  in  1  slave acknowledge.

Function
REQ-022 The state machine SHALL have three states: IDLE, BUSY and WAIT_FOR_STALL.
REQ-023 IDLE with cpu_req_i=1 and flush_i=0: on the next edge, register addr, data, we and sel onto the wishbone_*_o outputs, assert stb and cyc, clear the timeout counter, and enter BUSY.
REQ-024 All wishbone_*_o outputs SHALL be registered and SHALL stay stable throughout BUSY.
REQ-025 cpu_stall_o SHALL be combinational:
  - 1 in IDLE when cpu_req_i=1 and flush_i=0.
  - 1 in BUSY unless wishbone_ack_i=1 in that cycle.
  - 0 in all other cases.
REQ-026 BUSY with wishbone_ack_i=1:
  - deassert stb/cyc, and force we/sel to 0, on the next edge;
  - capture wishbone_data_i into the read buffer (reads only; the buffer is 0 after a write);
  - next state is WAIT_FOR_STALL if stall_i=1, else IDLE.
REQ-027 In the ack cycle, cpu_data_o SHALL present wishbone_data_i combinationally; in every other cycle it SHALL present the read buffer.
REQ-028 BUSY with flush_i=1 SHALL take priority over ack and timeout: deassert stb/cyc on the next edge, discard the result (buffer set to 0), and return to IDLE.
REQ-029 BUSY without ack: increment the 16-bit counter each cycle; on the cycle the counter equals TIMEOUT-1, deassert stb/cyc, pulse cpu_err_o for exactly one cycle, set the buffer to 0, and return to IDLE.
REQ-030 WAIT_FOR_STALL:
  - hold the read buffer;
  - keep cpu_stall_o=0;
  - go to IDLE on the first cycle with stall_i=0 or flush_i=1;
  - ignore cpu_req_i.
REQ-031 After every ack, the module SHALL spend at least one cycle in IDLE before a new cycle starts; stb is never asserted on two consecutive transactions without a gap.
REQ-032 stb and cyc SHALL always be equal.

Reset
REQ-033 rst=1 SHALL, on the next edge:
  - set the state to IDLE;
  - drive every wishbone_*_o output, cpu_err_o, the counter and the read buffer to 0.
REQ-034 rst mid-BUSY SHALL drop cyc/stb on the next edge and SHALL ignore an ack arriving in the same cycle.

Structure
REQ-035 A shared package SHALL hold the state encodings (IDLE=2'd0, BUSY=2'd1, WAIT_FOR_STALL=2'd2), WB_ADDR_W=32, WB_DATA_W=32 and WB_SEL_W=4.
REQ-036 The design SHALL be a single module with no sub-modules; it connects directly to the wishbone_*_i ports of bus.

Verification
REQ-037 Read: req, addr=0x00000010, we=0, sel=0xF; slave acks 3 cycles later with 0xDEADBEEF -> stb/cyc high for 3 cycles, cpu_data_o=0xDEADBEEF in the ack cycle, cpu_stall_o falls in the ack cycle.
REQ-038 Write: addr=0x20, data=0x12345678, sel=0x3; ack after 1 cycle -> wishbone_data_o=0x12345678 and select=0x3 stable until ack; cyc drops next edge.
REQ-039 Stall: read acked with 0xA5A5A5A5 while stall_i=1 for 4 cycles -> WAIT_FOR_STALL, cpu_data_o holds 0xA5A5A5A5 for all 4 cycles, IDLE when stall_i falls.
REQ-040 Flush: flush_i=1 in the same cycle as ack -> result discarded, cpu_data_o=0, IDLE, no cpu_err_o.
REQ-041 Timeout: TIMEOUT=8, no ack -> cyc drops after exactly 8 BUSY cycles, cpu_err_o high for one cycle.
REQ-042 Reset: rst asserted in BUSY cycle 2 -> all outputs 0 next edge; an ack in that cycle is ignored.
